// File: rtl/icache_pkg.sv
// Shared constants, FSM state type and counter helper for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned OFS_LSB = 2;
  localparam int unsigned OFS_W   = 3;
  localparam int unsigned IDX_LSB = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic {
    StIdle,
    StRefill
  } state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, data and valid storage: one write port, one combinational read port, whole-array flush.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_BITS = 256,
  localparam int unsigned IDX_W    = $clog2(NUM_LINES),
  localparam int unsigned TAG_W    = ADDR_W - IDX_LSB - IDX_W
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 wr_en_i,
  input  logic                 wr_valid_i,
  input  logic [IDX_W-1:0]     wr_idx_i,
  input  logic [TAG_W-1:0]     wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_line_i,
  input  logic [IDX_W-1:0]     rd_idx_i,
  input  logic [TAG_W-1:0]     rd_tag_i,
  output logic                 hit_o,
  output logic [LINE_BITS-1:0] rd_line_o
);

  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_line_i;
    end
  end

  // A write in the flush cycle still lands; wr_valid_i decides whether it survives.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      if (flush_i) valid_q <= '0;
      if (wr_en_i) valid_q[wr_idx_i] <= wr_valid_i;
    end
  end

  always_comb begin
    hit_o     = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    rd_line_o = data_q[rd_idx_i];
  end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: zero-latency hit path, single-line refill FSM,
// whole-cache flush and saturating hit/miss counters.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [ADDR_W-1:0]    Instr_address_2IM,
  input  logic                 fetch_req,
  input  logic                 flush,
  output logic [31:0]          Instr1_fIM,
  output logic                 instr_valid,
  output logic                 FREEZE,
  output logic                 misaligned,
  output logic                 iBlkRead,
  output logic [ADDR_W-1:0]    iBlk_address,
  input  logic [LINE_BITS-1:0] block_read_fIM,
  input  logic                 iBlk_ready,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - IDX_LSB - IDX_W;

  state_e               state_q;
  logic                 flush_pend_q;
  logic                 resume_q;
  logic                 hit;
  logic                 lookup;
  logic                 do_hit;
  logic                 do_miss;
  logic                 fill;
  logic [OFS_W-1:0]     ofs;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [7:0]           word_lsb;
  logic [LINE_BITS-1:0] rd_line;

  assign ofs      = Instr_address_2IM[IDX_LSB-1:OFS_LSB];
  assign idx      = Instr_address_2IM[IDX_LSB+IDX_W-1:IDX_LSB];
  assign tag      = Instr_address_2IM[ADDR_W-1:IDX_LSB+IDX_W];
  assign word_lsb = {ofs, 5'd0};

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .ADDR_W    (ADDR_W),
    .LINE_BITS (LINE_BITS)
  ) u_array (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .flush_i    (flush),
    .wr_en_i    (fill),
    .wr_valid_i (!(flush_pend_q || flush)),
    .wr_idx_i   (iBlk_address[IDX_LSB+IDX_W-1:IDX_LSB]),
    .wr_tag_i   (iBlk_address[ADDR_W-1:IDX_LSB+IDX_W]),
    .wr_line_i  (block_read_fIM),
    .rd_idx_i   (idx),
    .rd_tag_i   (tag),
    .hit_o      (hit),
    .rd_line_o  (rd_line)
  );

  // Outputs are forced quiet while reset is held.
  always_comb begin
    lookup      = RESET && (state_q == StIdle) && fetch_req;
    do_hit      = lookup && hit;
    do_miss     = lookup && !hit;
    fill        = (state_q == StRefill) && iBlk_ready;
    Instr1_fIM  = do_hit ? rd_line[word_lsb +: 32] : NOP_INSTR;
    instr_valid = do_hit;
    FREEZE      = do_miss || (RESET && (state_q == StRefill));
    misaligned  = fetch_req && (|Instr_address_2IM[1:0]);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= StIdle;
      iBlkRead     <= 1'b0;
      iBlk_address <= '0;
      flush_pend_q <= 1'b0;
      resume_q     <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
    end else begin
      resume_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (do_miss) begin
            state_q      <= StRefill;
            iBlkRead     <= 1'b1;
            iBlk_address <= {Instr_address_2IM[ADDR_W-1:IDX_LSB], {IDX_LSB{1'b0}}};
            miss_count   <= sat_inc(miss_count);
          end else if (do_hit && !resume_q) begin
            // The first hit after a refill is the stalled fetch completing, not a new hit.
            hit_count <= sat_inc(hit_count);
          end
        end
        StRefill: begin
          if (flush) flush_pend_q <= 1'b1;
          if (iBlk_ready) begin
            state_q      <= StIdle;
            iBlkRead     <= 1'b0;
            flush_pend_q <= 1'b0;
            resume_q     <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed self-checking bench for icache_ctrl: cold miss, sequential hits, conflict eviction,
// flush during refill and in idle, reset mid-refill, misaligned and idle fetches.
module tb_icache_ctrl;

  logic         CLK;
  logic         RESET;
  logic [31:0]  addr;
  logic         fetch_req;
  logic         flush;
  logic [31:0]  instr;
  logic         instr_valid;
  logic         freeze;
  logic         misaligned;
  logic         blk_read;
  logic [31:0]  blk_addr;
  logic [255:0] blk_data;
  logic         blk_ready;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [255:0] line_a, line_b, line_c;

  icache_ctrl #(
    .NUM_LINES (64),
    .ADDR_W    (32),
    .LINE_BITS (256)
  ) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .Instr_address_2IM (addr),
    .fetch_req         (fetch_req),
    .flush             (flush),
    .Instr1_fIM        (instr),
    .instr_valid       (instr_valid),
    .FREEZE            (freeze),
    .misaligned        (misaligned),
    .iBlkRead          (blk_read),
    .iBlk_address      (blk_addr),
    .block_read_fIM    (blk_data),
    .iBlk_ready        (blk_ready),
    .hit_count         (hit_count),
    .miss_count        (miss_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = base + step * i;
    return l;
  endfunction

  // Entered during the miss cycle; returns settled in the first IDLE cycle after the fill.
  task automatic do_refill(input logic [255:0] line, input int delay, input bit flush_rdy,
                           input logic [31:0] exp_addr);
    tick; settle;
    check("refill_rd", blk_read, 1);
    check("refill_addr", blk_addr, exp_addr);
    check("refill_frz", freeze, 1);
    check("refill_vld", instr_valid, 0);
    for (int i = 0; i < delay; i++) begin
      tick; settle;
      check("wait_frz", freeze, 1);
      check("wait_rd", blk_read, 1);
    end
    blk_ready = 1'b1;
    blk_data  = line;
    flush     = flush_rdy;
    settle;
    check("rdy_frz", freeze, 1);
    tick;
    blk_ready = 1'b0;
    flush     = 1'b0;
    blk_data  = '0;
    settle;
    check("drop_rd", blk_read, 0);
  endtask

  initial begin
    line_a = mk_line(32'h1111_1111, 32'h1111_1111);
    line_b = mk_line(32'hB000_0000, 32'h1);
    line_c = mk_line(32'hC000_0000, 32'h1);

    RESET     = 1'b0;
    fetch_req = 1'b1;
    addr      = 32'h0040_0004;
    flush     = 1'b0;
    blk_ready = 1'b0;
    blk_data  = '0;

    // Reset state, with a fetch request held to confirm outputs stay quiet
    tick; tick; settle;
    check("rst_instr", instr, 32'h0);
    check("rst_vld", instr_valid, 0);
    check("rst_frz", freeze, 0);
    check("rst_rd", blk_read, 0);
    check("rst_baddr", blk_addr, 32'h0);
    check("rst_hits", hit_count, 0);
    check("rst_miss", miss_count, 0);

    // Cold miss, memory answers on the third refill cycle
    RESET = 1'b1;
    settle;
    check("cold_frz", freeze, 1);
    check("cold_vld", instr_valid, 0);
    check("cold_mis", misaligned, 0);
    do_refill(line_a, 2, 1'b0, 32'h0040_0000);
    check("resume_instr", instr, 32'h2222_2222);
    check("resume_vld", instr_valid, 1);
    check("resume_frz", freeze, 0);
    check("resume_miss", miss_count, 1);
    check("resume_hits", hit_count, 0);

    tick; settle;
    check("hold_vld", instr_valid, 1);
    check("hold_hits", hit_count, 0);

    // Sequential hits over the whole line
    for (int i = 0; i < 8; i++) begin
      tick;
      addr = 32'h0040_0000 + 32'(4 * i);
      settle;
      check("seq_vld", instr_valid, 1);
      check("seq_frz", freeze, 0);
      check("seq_instr", instr, 32'h1111_1111 * 32'(i + 1));
    end

    // Idle fetch: no output, no counter change
    tick;
    fetch_req = 1'b0;
    addr      = 32'h0040_0004;
    settle;
    check("seq_hits", hit_count, 9);
    check("idle_instr", instr, 32'h0);
    check("idle_vld", instr_valid, 0);
    check("idle_frz", freeze, 0);
    tick; settle;
    check("idle_hits", hit_count, 9);
    check("idle_miss", miss_count, 1);

    // Misaligned fetch still hits on word 1
    tick;
    fetch_req = 1'b1;
    addr      = 32'h0040_0006;
    settle;
    check("mis_flag", misaligned, 1);
    check("mis_instr", instr, 32'h2222_2222);
    check("mis_vld", instr_valid, 1);

    // Conflict eviction on index 0
    tick;
    addr = 32'h0040_0800;
    settle;
    check("mis_hits", hit_count, 10);
    check("conf1_frz", freeze, 1);
    check("conf1_vld", instr_valid, 0);
    do_refill(line_b, 1, 1'b0, 32'h0040_0800);
    check("conf1_instr", instr, 32'hB000_0000);
    check("conf1_miss", miss_count, 2);
    tick;
    addr = 32'h0040_0000;
    settle;
    check("conf2_frz", freeze, 1);
    do_refill(line_a, 0, 1'b0, 32'h0040_0000);
    check("conf2_instr", instr, 32'h1111_1111);
    check("conf2_miss", miss_count, 3);

    // Flush together with iBlk_ready: line written but left invalid
    tick;
    addr = 32'h0040_0020;
    settle;
    check("fl_frz", freeze, 1);
    do_refill(line_c, 1, 1'b1, 32'h0040_0020);
    check("fl_remiss_frz", freeze, 1);
    check("fl_remiss_vld", instr_valid, 0);
    check("fl_miss", miss_count, 4);
    do_refill(line_c, 0, 1'b0, 32'h0040_0020);
    check("fl_instr", instr, 32'hC000_0000);
    check("fl_vld", instr_valid, 1);
    check("fl_miss2", miss_count, 5);

    // Flush in IDLE: same-cycle lookup uses pre-flush valid bits
    tick;
    flush = 1'b1;
    settle;
    check("ifl_vld", instr_valid, 1);
    check("ifl_instr", instr, 32'hC000_0000);
    tick;
    flush = 1'b0;
    settle;
    check("ifl_post_frz", freeze, 1);
    check("ifl_post_vld", instr_valid, 0);

    // Reset while a refill is outstanding
    tick; settle;
    check("rr_rd", blk_read, 1);
    check("rr_miss", miss_count, 6);
    RESET = 1'b0;
    settle;
    check("rr_frz", freeze, 0);
    check("rr_vld", instr_valid, 0);
    check("rr_instr", instr, 32'h0);
    tick; settle;
    check("rr_rd_low", blk_read, 0);
    check("rr_baddr", blk_addr, 32'h0);
    check("rr_hits0", hit_count, 0);
    check("rr_miss0", miss_count, 0);
    RESET = 1'b1;
    settle;
    check("rr_remiss_frz", freeze, 1);
    do_refill(line_c, 0, 1'b0, 32'h0040_0020);
    check("rr_instr2", instr, 32'hC000_0000);
    check("rr_miss1", miss_count, 1);
    check("rr_hits1", hit_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
